// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline sequencing logic: FSM state
// encodings, the hazard control bundle and NOP field values.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // One bit per pipeline register control.
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_hold;
        logic idex_bubble;
        logic exmem_hold;
    } pipe_ctrl_t;

    // NOP values loaded by a flush or bubble. The ID/EX register also uses
    // them as its reset values, so a bubble is indistinguishable from reset.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic        NOP_REG_WEN = 1'b0;
    localparam logic        NOP_DM_REQ  = 1'b0;
    localparam logic        NOP_DM_WEN  = 1'b0;

    localparam pipe_ctrl_t CTRL_IDLE = '{
        pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b0,
        idex_hold: 1'b0, idex_bubble: 1'b0, exmem_hold: 1'b0};

    // While in reset the front registers are forced to NOPs.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
        idex_hold: 1'b0, idex_bubble: 1'b1, exmem_hold: 1'b0};

    // Freeze the whole pipeline up to and including EX/MEM.
    localparam pipe_ctrl_t CTRL_ALL_HOLD = '{
        pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
        idex_hold: 1'b1, idex_bubble: 1'b0, exmem_hold: 1'b1};

    // Discard the wrong-path instructions in IF/ID and ID.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
        idex_hold: 1'b0, idex_bubble: 1'b1, exmem_hold: 1'b0};

    // Keep the consumer in ID and send a bubble behind the load.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
        idex_hold: 1'b0, idex_bubble: 1'b1, exmem_hold: 1'b0};

    // Frozen after a watchdog timeout; ID/EX also presents a NOP.
    localparam pipe_ctrl_t CTRL_HALT = '{
        pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
        idex_hold: 1'b1, idex_bubble: 1'b1, exmem_hold: 1'b1};

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 is never a real dependency.
module pipe_hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_load,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    assign load_use  = ex_load && (ex_rd_addr != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: turns load-use hazards, EX redirects and
// data-memory waits into hold/flush/bubble controls, with a memory-wait
// watchdog and a saturating stall counter.
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_load_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_hold_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t           state;
    logic [TO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;
    logic             load_use;
    logic             mem_stall;
    pipe_ctrl_t       ctrl;

    pipe_hazard_detect u_detect (
        .id_rs1_addr (id_rs1_addr_i),
        .id_rs2_addr (id_rs2_addr_i),
        .id_rs1_used (id_rs1_used_i),
        .id_rs2_used (id_rs2_used_i),
        .ex_rd_addr  (ex_rd_addr_i),
        .ex_load     (ex_load_i),
        .load_use    (load_use)
    );

    // In RUN a new access stalls only if the memory is not ready at once;
    // once waiting, only the ready strobe matters.
    assign mem_stall = (state == MEM_WAIT) ? !mem_ready_i
                                           : (mem_req_i && !mem_ready_i);

    // Select this cycle's controls; reset forces NOPs in asynchronously.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_stall)          ctrl = CTRL_ALL_HOLD;
                    else if (ex_redirect_i) ctrl = CTRL_REDIRECT;
                    else if (load_use)      ctrl = CTRL_LOAD_USE;
                    else                    ctrl = CTRL_IDLE;
                end
                HALT:    ctrl = CTRL_HALT;
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    // Sequencing state, watchdog, sticky error and stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (ctrl.pc_hold && (state != HALT) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                        if ((MEM_TIMEOUT != 0) && (wait_cnt == TO_W'(MEM_TIMEOUT))) begin
                            state <= HALT;
                            err   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign pc_hold_o     = ctrl.pc_hold;
    assign ifid_hold_o   = ctrl.ifid_hold;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_hold_o   = ctrl.idex_hold;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign exmem_hold_o  = ctrl.exmem_hold;
    assign err_o         = err;
    assign state_o       = state;
    assign stall_cnt_o   = stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core.
- Drives hold, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sources: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait handshakes.
- Includes a memory-wait watchdog and a stall performance counter.

Parameters:
- CNT_W, 16: width of the stall-cycle counter.
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before halting. 0 disables the watchdog.
- TO_W, 8: width of the wait counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  Clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- id_rs1_addr_i  in  5  rs1 of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_rd_addr_i  in  5  rd of the instruction in EX.
- ex_load_i  in  1  EX instruction is a load.
- ex_redirect_i  in  1  Taken branch or jump resolved in EX.
- mem_req_i  in  1  MEM stage is accessing data memory.
- mem_ready_i  in  1  Data memory completes the access this cycle.
- pc_hold_o  out  1  Hold the PC.
- ifid_hold_o  out  1  Hold the IF/ID register.
- ifid_flush_o  out  1  Load a NOP into IF/ID.
- idex_hold_o  out  1  Hold the ID/EX register.
- idex_bubble_o  out  1  Load a NOP into ID/EX (REG_WEN/DM inactive values).
- exmem_hold_o  out  1  Hold the EX/MEM register.
- err_o  out  1  Sticky watchdog timeout flag.
- state_o  out  2  Current state.
- stall_cnt_o  out  CNT_W  Saturating count of stall cycles.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = RUN; wait_cnt = 0; stall_cnt_o = 0; err_o = 0.
  - While rst_n = 0: all holds = 0, ifid_flush_o = 1, idex_bubble_o = 1.
- Control outputs are combinational from state and inputs, taking effect in the same cycle. State and counters are registered.
- Load-use hazard (lu):
  - Condition: ex_load_i & ex_rd_addr_i != 0 & ((id_rs1_used_i & id_rs1_addr_i == ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i == ex_rd_addr_i)).
- Memory wait (mw): mem_req_i & ~mem_ready_i.
- RUN, evaluated by priority:
  1. mw: assert pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o. Next state MEM_WAIT, wait_cnt <= 1.
  2. ex_redirect_i: assert ifid_flush_o and idex_bubble_o, no holds. Redirect overrides lu, because the ID instruction is discarded.
  3. lu: assert pc_hold_o, ifid_hold_o, idex_bubble_o. This gives exactly one stall cycle, since the load advances to MEM next cycle.
  4. Otherwise: all outputs 0.
- MEM_WAIT:
  - While mem_ready_i = 0:
    - All four holds asserted; EX inputs stay stable.
    - wait_cnt increments.
    - If MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT, next state HALT and err_o <= 1.
  - When mem_ready_i = 1: next state RUN, wait_cnt <= 0. Outputs this cycle follow RUN rules 2-4 (mw is false).
  - A pending redirect or lu is therefore acted on in the release cycle.
- HALT:
  - Outputs: all holds = 1, idex_bubble_o = 1.
  - Ignores all inputs; exits only on reset.
  - err_o stays 1.
- stall_cnt_o: increments on every cycle with pc_hold_o = 1 and state != HALT. Saturates at all-ones with no wrap.
- Mid-operation reset: immediately returns to RUN, counters clear, and outputs take their reset values asynchronously.
- x0 never triggers lu.
- A request with mem_ready_i = 1 in the same cycle causes no stall.

Decomposition:
- Shared package (rv_pipe_pkg):
  - State encodings: RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2.
  - NOP/bubble control constants shared with the ID/EX register's reset values.
- Sub-module pipe_hazard_detect: combinational lu compare (addresses, used bits, x0 exclusion), instantiated once.

Test Plan:
- Load-use: EX load with rd = 5, ID has rs1 = 5 and used -> exactly 1 cycle of pc_hold_o, ifid_hold_o, idex_bubble_o; stall_cnt_o = 1.
- x0 case: EX load with rd = 0, ID rs2 = 0 used -> no stall, stall_cnt_o unchanged.
- Redirect with lu in the same cycle -> ifid_flush_o = 1, idex_bubble_o = 1, pc_hold_o = 0.
- Memory wait: mem_req_i = 1, mem_ready_i low for 3 cycles then high -> 3 cycles of all holds, state_o = 1, then RUN; stall_cnt_o = 3.
- Watchdog: MEM_TIMEOUT = 4, ready never asserted -> state_o = 2 and err_o = 1 after 4 wait cycles; holds stay asserted until rst_n pulses low; after reset everything clears.
- Saturation: CNT_W = 4, 20 load-use stalls -> stall_cnt_o = 15.
